// File: rtl/reg_dump_pkg.sv
// Shared types and default sizes for the register-file dump engine.
// When REG_DUMP_CHECKSUM_EN is defined, an extra CSUM state is added for the
// trailing XOR checksum beat.
package reg_dump_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_SEND   = 3'd2,
        ST_FINISH = 3'd3
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        ST_CSUM   = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/reg_dump_unit.sv
// Register-file read-out engine.
//
// A start pulse walks registers FIRST_REG..NUM_REGS-1 through a dedicated
// combinational read port. Each value is streamed out on a valid/ready channel.
// Every register costs one READ cycle and at least one SEND cycle, so the rate
// is one beat per two cycles when the sink is always ready.
//
// Optional feature macro: REG_DUMP_CHECKSUM_EN. When it is defined, one more
// beat follows the last register. That beat carries the XOR of all dumped
// values, has index 0, and is the only beat flagged last.
module reg_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_idx,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] didx_q, didx_d;
    logic              last_q, last_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    // Next-state and beat-register logic. Abort overrides every transition at the end.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        didx_d  = didx_q;
        last_d  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    idx_d   = FIRST_IDX;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_READ: begin
                // The register value is sampled here, not when the dump starts.
                data_d  = rf_rdata;
                didx_d  = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
                last_d  = 1'b0;
                csum_d  = csum_q ^ rf_rdata;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dout_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    if (idx_q == LAST_IDX) begin
                        // The checksum is already complete, because the last
                        // register was folded in during its READ cycle.
                        data_d  = csum_q;
                        didx_d  = '0;
                        last_d  = 1'b1;
                        state_d = ST_CSUM;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
`else
                    if (last_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (dout_ready) begin
                    state_d = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort also blocks a simultaneous start in IDLE.
        if (abort) begin
            state_d = ST_IDLE;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_d  = '0;
`endif
        end
    end

    // State and beat registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
            last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            last_q  <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // The read address is driven only during READ, so the port is otherwise quiet.
    assign rf_raddr   = (state_q == ST_READ) ? idx_q : '0;
`ifdef REG_DUMP_CHECKSUM_EN
    assign dout_valid = (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
    assign dout_valid = (state_q == ST_SEND);
`endif
    assign dout_data  = data_q;
    assign dout_idx   = didx_q;
    assign dout_last  = last_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit. The expected beat stream is built
// directly from the register-file contents. A negedge monitor compares every
// valid beat, the done pulse and stall stability against that stream.
module tb_reg_dump_unit;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 32;
    localparam int FIRST = 0;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NBEATS = NR - FIRST + 1;
`else
    localparam int NBEATS = NR - FIRST;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort, dout_ready;
    logic [AW-1:0] rf_raddr, dout_idx;
    logic [DW-1:0] rf_rdata, dout_data;
    logic          dout_valid, dout_last, busy, done;

    logic [DW-1:0] rf [NR];
    assign rf_rdata = rf[rf_raddr];

    always #5 clk = ~clk;

    reg_dump_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .FIRST_REG(FIRST)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_idx(dout_idx), .dout_last(dout_last),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    int            tests = 0;
    int            fails = 0;
    bit            done_exp = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    int            beat_cnt = 0;
    logic [DW-1:0] idx_last_data;
    bit            rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: a dump is the list of current register values in index order.
    task automatic push_dump();
        beat_t         b;
        logic [DW-1:0] x = '0;
        for (int i = FIRST; i < NR; i++) begin
            b.data = rf[i];
            b.idx  = AW'(i);
`ifdef REG_DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == NR - 1);
`endif
            x = x ^ rf[i];
            exp_q.push_back(b);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        b.data = x;
        b.idx  = '0;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // Compare process: runs every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
        end else begin
            chk("done_pulse", done, done_exp);
            done_exp = 1'b0;
            if (prev_stall) begin
                chk("stall_valid", dout_valid, 1);
                chk("stall_data", dout_data, prev_data);
            end
            if (dout_valid) begin
                chk("busy_in_send", busy, 1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got idx %0d data 0x%0h want no beat", dout_idx, dout_data);
                end else begin
                    chk("beat_data", dout_data, exp_q[0].data);
                    chk("beat_idx", dout_idx, exp_q[0].idx);
                    chk("beat_last", dout_last, exp_q[0].last);
                    if (dout_ready && !abort) begin
                        beat_cnt++;
                        if (exp_q[0].idx == AW'(NR - 1) && !exp_q[0].last) idx_last_data = dout_data;
`ifndef REG_DUMP_CHECKSUM_EN
                        if (exp_q[0].idx == AW'(NR - 1)) idx_last_data = dout_data;
`endif
                        done_exp = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = dout_valid && !dout_ready && !abort;
            prev_data  = dout_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start();
        beat_cnt = 0;
        push_dump();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            step();
            n++;
        end
        chk(name, done, 1);
        step();
    endtask

    task automatic run_to_idx(input int target);
        int n = 0;
        while (!(dout_valid && dout_idx == AW'(target)) && n < 300) begin
            dout_ready = 1'b1;
            step();
            n++;
        end
        dout_ready = 1'b0;
        chk("reach_idx", (dout_valid && dout_idx == AW'(target)), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_data"}, dout_data, 0);
        chk({tag, "_idx"}, dout_idx, 0);
        chk({tag, "_last"}, dout_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_raddr"}, rf_raddr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
        for (int i = 0; i < NR; i++) rf[i] = DW'(i * 32'h11);
        repeat (3) step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // Full dump with the sink always ready: check latency, beat count and rate.
        dout_ready = 1'b1;
        do_start();
        chk("lat_read_valid", dout_valid, 0);
        chk("lat_raddr", rf_raddr, FIRST);
        chk("lat_busy", busy, 1);
        step();
        chk("lat_valid", dout_valid, 1);
        chk("lat_first_idx", dout_idx, FIRST);
        wait_done("dump1_timeout", 1000, n);
`ifdef REG_DUMP_CHECKSUM_EN
        chk("dump1_cycles", n, 64);
`else
        chk("dump1_cycles", n, 63);
`endif
        chk("dump1_beats", beat_cnt, NBEATS);
        chk("dump1_idx31_data", idx_last_data, 32'h20F);
        chk("dump1_busy_after", busy, 0);
        chk("dump1_queue", exp_q.size(), 0);

        // Same dump, with the sink stalling pseudo-randomly.
        rand_ready = 1'b1;
        do_start();
        wait_done("dump2_timeout", 2000, n);
        rand_ready = 1'b0;
        chk("dump2_beats", beat_cnt, NBEATS);
        chk("dump2_queue", exp_q.size(), 0);

        // Abort while the beat for idx 5 is being presented.
        do_start();
        run_to_idx(5);
        abort = 1'b1;
        step();
        chk("abort_valid", dout_valid, 0);
        chk("abort_busy", busy, 0);
        abort = 1'b0;
        exp_q.delete();
        repeat (4) step();
        chk("abort_no_done", done, 0);
        abort = 1'b1; start = 1'b1;
        step();
        chk("abort_start_idle", busy, 0);
        abort = 1'b0; start = 1'b0;
        step();
        dout_ready = 1'b1;
        do_start();
        wait_done("dump3_timeout", 1000, n);
        chk("dump3_beats", beat_cnt, NBEATS);

        // Asynchronous reset in the middle of the dump, at idx 12.
        do_start();
        run_to_idx(12);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        dout_ready = 1'b1;
        do_start();
        wait_done("dump4_timeout", 1000, n);
        chk("dump4_beats", beat_cnt, NBEATS);

        // Random contents, random ready, start pulses while busy, and one random abort.
        for (int d = 0; d < 6; d++) begin
            int abort_at;
            bit aborted;
            for (int i = 0; i < NR; i++) rf[i] = $urandom;
            abort_at = (d == 3) ? int'($urandom_range(2, 40)) : -1;
            aborted  = 1'b0;
            rand_ready = 1'b1;
            do_start();
            n = 0;
            while (!done && n < 2000) begin
                if (n == abort_at) begin
                    start = 1'b0; dout_ready = 1'b0; rand_ready = 1'b0;
                    abort = 1'b1;
                    step();
                    chk("rand_abort_valid", dout_valid, 0);
                    abort = 1'b0;
                    exp_q.delete();
                    step();
                    aborted = 1'b1;
                    break;
                end
                step();
                n++;
                if (start) start = 1'b0;
                else if ($urandom_range(0, 19) == 0) start = 1'b1;
            end
            start = 1'b0;
            rand_ready = 1'b0;
            if (!aborted) begin
                chk("rand_done", done, 1);
                step();
                chk("rand_beats", beat_cnt, NBEATS);
                chk("rand_queue", exp_q.size(), 0);
            end
            step();
            chk("rand_idle", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
